// File: rtl/dmem_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module   : dmem_arbiter_if
//  Purpose  : Bundles the CPU, auxiliary-requester and DMEM port signals
//             around the data-memory arbiter.
//  Revision : 1.0 - initial release
// ============================================================================
interface dmem_arbiter_if #(
   parameter int ADDR_W = 12
) ();

   // CPU M-stage side
   logic              cpu_req;
   logic [3:0]        cpu_we;
   logic [ADDR_W-1:0] cpu_addr;
   logic [31:0]       cpu_wdata;
   logic              cpu_stall;
   logic [31:0]       cpu_rdata;

   // Auxiliary requester side (bootloader / debug DMA)
   logic              aux_valid;
   logic              aux_ready;
   logic [3:0]        aux_we;
   logic [ADDR_W-1:0] aux_addr;
   logic [31:0]       aux_wdata;
   logic              aux_rvalid;
   logic [31:0]       aux_rdata;

   // DMEM block-RAM port
   logic              mem_en;
   logic [3:0]        mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [31:0]       mem_wdata;
   logic [31:0]       mem_rdata;

   // Arbiter view
   modport slave (
      input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
      output cpu_stall, cpu_rdata,
      input  aux_valid, aux_we, aux_addr, aux_wdata,
      output aux_ready, aux_rvalid, aux_rdata,
      output mem_en, mem_we, mem_addr, mem_wdata,
      input  mem_rdata
   );

   // Environment view: requesters plus the memory itself
   modport master (
      output cpu_req, cpu_we, cpu_addr, cpu_wdata,
      input  cpu_stall, cpu_rdata,
      output aux_valid, aux_we, aux_addr, aux_wdata,
      input  aux_ready, aux_rvalid, aux_rdata,
      input  mem_en, mem_we, mem_addr, mem_wdata,
      output mem_rdata
   );

endinterface : dmem_arbiter_if
`default_nettype wire

// File: rtl/dmem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : dmem_arbiter
//  Purpose  : Shares the single DMEM port between the CPU (fixed priority)
//             and an auxiliary requester. A starvation counter forces one
//             aux grant (stalling the CPU for that cycle) after STARVE_LIMIT
//             consecutive waiting cycles. Aux reads return with a 1-cycle
//             valid strobe.
//  Revision : 1.0 - initial release
// ============================================================================
module dmem_arbiter #(
   parameter int ADDR_W       = 12,
   parameter int STARVE_LIMIT = 8     // legal range 1..255
) (
   input  logic            clk,
   input  logic            rst,
   dmem_arbiter_if.slave   bus_io
);

   typedef enum logic [0:0] {
      ST_NORMAL    = 1'b0,
      ST_FORCE_AUX = 1'b1
   } state_t;

   // Compared against the 9-bit incremented count so 255 cannot wrap
   localparam logic [8:0] c_limit = 9'(STARVE_LIMIT);

   state_t      state_q, state_d;
   logic [7:0]  wcnt_q,  wcnt_d;
   logic        aux_rd_q, aux_rd_d;

   logic        w_grant_cpu;
   logic        w_grant_aux;
   logic        w_cpu_stall;
   logic [8:0]  w_wcnt_inc;

   assign w_wcnt_inc = {1'b0, wcnt_q} + 9'd1;

   // State, wait counter and pending-aux-read flag
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= ST_NORMAL;
         wcnt_q   <= 8'd0;
         aux_rd_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         wcnt_q   <= wcnt_d;
         aux_rd_q <= aux_rd_d;
      end
   end

   // Grant decision; everything is suppressed while reset is held so an
   // abandoned FORCE_AUX cycle cannot leak an access to the RAM
   always_comb begin
      w_grant_cpu = 1'b0;
      w_grant_aux = 1'b0;
      w_cpu_stall = 1'b0;
      if (!rst) begin
         case (state_q)
            ST_FORCE_AUX: begin
               if (bus_io.aux_valid) begin
                  w_grant_aux = 1'b1;
                  w_cpu_stall = bus_io.cpu_req;
               end else if (bus_io.cpu_req) begin
                  // aux dropped its request: fall back to normal priority
                  w_grant_cpu = 1'b1;
               end
            end
            default: begin
               if (bus_io.cpu_req) begin
                  w_grant_cpu = 1'b1;
               end else if (bus_io.aux_valid) begin
                  w_grant_aux = 1'b1;
               end
            end
         endcase
      end
   end

   // Next state and starvation counter; FORCE_AUX lasts exactly one cycle
   always_comb begin
      state_d  = ST_NORMAL;
      wcnt_d   = wcnt_q;
      aux_rd_d = w_grant_aux && (bus_io.aux_we == 4'b0000);
      if (w_grant_aux) begin
         wcnt_d = 8'd0;
      end else if (bus_io.aux_valid) begin
         if (wcnt_q != 8'hFF) begin
            wcnt_d = w_wcnt_inc[7:0];
         end
         if (w_wcnt_inc == c_limit) begin
            state_d = ST_FORCE_AUX;
         end
      end else begin
         wcnt_d = 8'd0;
      end
   end

   // DMEM port mux and requester-side outputs
   always_comb begin
      bus_io.mem_en    = w_grant_cpu | w_grant_aux;
      bus_io.mem_we    = 4'b0000;
      bus_io.mem_addr  = '0;
      bus_io.mem_wdata = 32'd0;
      if (w_grant_aux) begin
         bus_io.mem_we    = bus_io.aux_we;
         bus_io.mem_addr  = bus_io.aux_addr;
         bus_io.mem_wdata = bus_io.aux_wdata;
      end else if (w_grant_cpu) begin
         bus_io.mem_we    = bus_io.cpu_we;
         bus_io.mem_addr  = bus_io.cpu_addr;
         bus_io.mem_wdata = bus_io.cpu_wdata;
      end
      bus_io.aux_ready  = w_grant_aux;
      bus_io.cpu_stall  = w_cpu_stall;
      bus_io.aux_rvalid = aux_rd_q;
      bus_io.aux_rdata  = bus_io.mem_rdata;
      bus_io.cpu_rdata  = bus_io.mem_rdata;
   end

endmodule : dmem_arbiter
`default_nettype wire

// File: doc/dmem_arbiter.md
# dmem_arbiter

Arbitrates the single data-memory block RAM port between the CPU M-stage access and one auxiliary requester (UART bootloader / debug DMA). The CPU has fixed priority, except that an aux starvation counter forces a single aux grant and stalls the CPU pipeline for that cycle. The block sits between the datapath's store-mask/address logic and the DMEM port. It returns read data to the aux side with a one-cycle-latency valid strobe.

## Interface
Parameters:
- ADDR_W, 12, word-address width of DMEM (addr = byte address [ADDR_W+1:2])
- STARVE_LIMIT, 8, consecutive cycles aux may wait before a forced aux grant (legal range 1..255)

Ports:
- clk  in  1  single clock; all state updates on posedge
- rst  in  1  synchronous, active-high reset
- cpu_req  in  1  CPU M-stage load or store this cycle
- cpu_we  in  4  byte write mask (bit3 = byte0, big-endian); 0000 = read
- cpu_addr  in  ADDR_W  CPU word address
- cpu_wdata  in  32  CPU store data
- cpu_stall  out  1  CPU must freeze the pipeline and re-present the same access next cycle
- cpu_rdata  out  32  DMEM read data; valid the cycle after a CPU read grant
- aux_valid  in  1  aux request pending
- aux_ready  out  1  aux request accepted this cycle
- aux_we  in  4  aux byte write mask; 0000 = read
- aux_addr  in  ADDR_W  aux word address
- aux_wdata  in  32  aux store data
- aux_rvalid  out  1  aux read data valid
- aux_rdata  out  32  aux read data
- mem_en  out  1  DMEM port enable
- mem_we  out  4  DMEM byte write enables
- mem_addr  out  ADDR_W  DMEM address
- mem_wdata  out  32  DMEM write data
- mem_rdata  in  32  DMEM read data, 1-cycle registered latency

## Operation
- State register: NORMAL, FORCE_AUX. Wait counter `wcnt`, 8 bits, saturating.
- At most one DMEM access per cycle. The grant is combinational from the current state and requests.
- NORMAL state:
  - cpu_req=1: grant CPU; cpu_stall=0; aux_ready=0.
  - cpu_req=0 and aux_valid=1: grant aux; aux_ready=1.
  - Neither request: mem_en=0, mem_we=0000.
- FORCE_AUX state:
  - aux_valid=1: grant aux; aux_ready=1; cpu_stall=cpu_req.
  - aux_valid=0 (handshake violation): grant CPU as in NORMAL; cpu_stall=0.
  - Next state is always NORMAL.
- wcnt update:
  - Cleared on any aux grant.
  - Incremented when aux_valid=1 and aux is not granted.
  - Cleared when aux_valid=0.
  - When it increments to STARVE_LIMIT: next state = FORCE_AUX.
- Mux: the granted requester's we/addr/wdata drive mem_*; mem_en=1 on any grant. Ungranted inputs are ignored.
- Aux handshake: aux_valid, aux_we, aux_addr and aux_wdata stay stable until aux_ready=1. aux_valid may be asserted again the cycle after ready.
- Read return: a registered flag `aux_rd_q` is set when aux is granted with aux_we=0000.
  - aux_rvalid = aux_rd_q.
  - aux_rdata = mem_rdata.
  - cpu_rdata = mem_rdata always (pass-through).
- Aux writes produce no aux_rvalid. CPU writes and reads never produce aux_rvalid.

## Timing
- Reset (rst=1 at an edge): state=NORMAL, wcnt=0, aux_rd_q=0.
  - While rst=1: aux_ready=0, cpu_stall=0, mem_en=0, mem_we=0000, aux_rvalid=0 (next cycle).
- Grant, aux_ready, cpu_stall and mem_* are combinational in the request cycle. Writes commit at the closing clock edge.
- Read latency: data appears 1 cycle after the grant cycle, for both requesters. aux_rvalid is high exactly 1 cycle.
- Worst-case aux wait under continuous cpu_req: STARVE_LIMIT cycles waiting, then a grant on cycle STARVE_LIMIT+1 (counting the first request cycle as 1).
- Back-to-back aux requests with cpu_req=0: one acceptance per cycle, aux_rvalid pipelined 1 cycle behind each read.
- cpu_stall is asserted for at most 1 cycle per FORCE_AUX entry. The CPU access retried in the next cycle (NORMAL) is always granted.
- Simultaneous requests in NORMAL with wcnt below the limit: CPU wins, wcnt increments.
- rst asserted mid-FORCE_AUX:
  - FORCE_AUX is abandoned; no aux grant occurs.
  - A pending aux_rd_q is cleared, so no stale aux_rvalid appears.

## Test plan
- Reset: hold rst 2 cycles with cpu_req=1 and aux_valid=1. Required: mem_en=0, aux_ready=0, cpu_stall=0 throughout; aux_rvalid=0 the cycle after release.
- CPU only: write cpu_we=1111, addr 0x010, data 0xDEADBEEF; then read addr 0x010. Required: cpu_rdata=0xDEADBEEF one cycle after the read grant; aux_rvalid stays 0.
- Aux only: write aux_we=1000, addr 0x020, data 0xAB000000, then read 0x020. Required: aux_ready high in each request cycle; aux_rvalid for 1 cycle with aux_rdata[31:24]=0xAB.
- Contention, STARVE_LIMIT=8: cpu_req=1 continuously, aux read asserted at cycle 0. Required:
  - aux_ready=0 for cycles 0-7.
  - Cycle 8: aux_ready=1, cpu_stall=1, mem_addr=aux_addr.
  - Cycle 9: cpu_stall=0, CPU granted, aux_rvalid=1.
- Handshake violation: drive wcnt to the limit, then drop aux_valid in the FORCE_AUX cycle. Required: CPU granted, cpu_stall=0, next state NORMAL, wcnt=0.
- Reset mid-operation: grant an aux read, assert rst in the following cycle. Required: aux_rvalid=0 the cycle after rst is sampled; state NORMAL, wcnt=0.
